// File: rtl/tiled_matrix_multiplier_pkg.sv
// Shared definitions for the tiled matrix multiplier: FSM encodings and width helpers.
package tiled_matrix_multiplier_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    // Product width plus enough headroom for an N-term dot product.
    function automatic int acc_width(input int data_w, input int n);
        return 2 * data_w + $clog2(n);
    endfunction

endpackage

// File: rtl/tiled_matrix_multiplier_mac_lane.sv
// One signed multiply-accumulate lane: acc += sext(a*b) when enabled, synchronous clear.
module tiled_matrix_multiplier_mac_lane #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 66
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic        [ACC_W-1:0]    prod_ext;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/tiled_matrix_multiplier.sv
// Tiled signed matrix multiplier: Z = A*B (or Z += A*B), P output columns per pass.
// state   | meaning
// IDLE    | waiting for start, A/B loadable
// COMPUTE | N cycles accumulating row i against column block jb
// WRITE   | one cycle storing the lane sums into Z
// DONE    | result ready, held until next start
module tiled_matrix_multiplier
    import tiled_matrix_multiplier_pkg::*;
#(
    parameter int N      = 4,
    parameter int P      = 2,
    parameter int DATA_W = 32,
    parameter int ACC_W  = acc_width(DATA_W, N),
    localparam int IW    = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [IW-1:0]     a_i,
    input  logic [IW-1:0]     a_j,
    input  logic              a_we,
    input  logic [DATA_W-1:0] b_in,
    input  logic [IW-1:0]     b_i,
    input  logic [IW-1:0]     b_j,
    input  logic              b_we,
    input  logic              start,
    input  logic              acc_mode,
    input  logic [IW-1:0]     z_i,
    input  logic [IW-1:0]     z_j,
    output logic [ACC_W-1:0]  z_out,
    output logic              busy,
    output logic              done
);

    localparam int NB = N / P;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] LAST_JB  = IW'(NB - 1);

    logic [1:0]        state;
    logic [IW-1:0]     i;
    logic [IW-1:0]     jb;
    logic [IW-1:0]     k;
    logic              acc_mode_q;
    logic              accept;
    logic              lane_clr;
    logic              lane_en;

    logic [DATA_W-1:0] a_mem [N][N];
    logic [DATA_W-1:0] b_mem [N][N];
    logic [ACC_W-1:0]  z_mem [N][N];
    logic [IW-1:0]     col   [P];
    logic [ACC_W-1:0]  acc   [P];

    // Guards non-power-of-2 N, where the index field can exceed N-1.
    function automatic logic in_range(input logic [IW-1:0] x);
        return {1'b0, x} < (IW+1)'(N);
    endfunction

    assign busy     = (state == ST_COMPUTE) || (state == ST_WRITE);
    assign done     = (state == ST_DONE);
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign lane_clr = accept || (state == ST_WRITE);
    assign lane_en  = (state == ST_COMPUTE);

    assign z_out = (in_range(z_i) && in_range(z_j)) ? z_mem[z_i][z_j] : '0;

    // A/B are deliberately left out of reset so a host load survives an abort.
    always_ff @(posedge clk) begin
        if (!busy && a_we && in_range(a_i) && in_range(a_j)) begin
            a_mem[a_i][a_j] <= a_in;
        end
        if (!busy && b_we && in_range(b_i) && in_range(b_j)) begin
            b_mem[b_i][b_j] <= b_in;
        end
    end

    for (genvar p = 0; p < P; p++) begin : g_lane
        assign col[p] = IW'(int'(jb) * P + p);

        tiled_matrix_multiplier_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (lane_clr),
            .en  (lane_en),
            .a   (a_mem[i][k]),
            .b   (b_mem[k][col[p]]),
            .acc (acc[p])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            i          <= '0;
            jb         <= '0;
            k          <= '0;
            acc_mode_q <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    z_mem[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_COMPUTE;
                        acc_mode_q <= acc_mode;
                        i          <= '0;
                        jb         <= '0;
                        k          <= '0;
                    end
                end
                ST_COMPUTE: begin
                    if (k == LAST_IDX) begin
                        state <= ST_WRITE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_WRITE: begin
                    for (int p = 0; p < P; p++) begin
                        z_mem[i][col[p]] <= acc_mode_q ? z_mem[i][col[p]] + acc[p] : acc[p];
                    end
                    k <= '0;
                    if (jb == LAST_JB) begin
                        jb <= '0;
                        if (i == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            i     <= i + 1'b1;
                            state <= ST_COMPUTE;
                        end
                    end else begin
                        jb    <= jb + 1'b1;
                        state <= ST_COMPUTE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tiled_matrix_multiplier.sv
// Directed bench: default 4x4/P=2 instance plus N=3/P=1 and N=P=4 instances sharing one stimulus bus.
module tb_tiled_matrix_multiplier;

    localparam int AW = 66;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   a_in, b_in;
    logic [1:0]    a_i, a_j, b_i, b_j, z_i, z_j;
    logic          a_we, b_we, start, acc_mode;
    logic [AW-1:0] z_out, z_out_n3, z_out_p4;
    logic          busy, done, busy_n3, done_n3, busy_p4, done_p4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tiled_matrix_multiplier #(.N(4), .P(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_i(a_i), .a_j(a_j), .a_we(a_we),
        .b_in(b_in), .b_i(b_i), .b_j(b_j), .b_we(b_we),
        .start(start), .acc_mode(acc_mode), .z_i(z_i), .z_j(z_j),
        .z_out(z_out), .busy(busy), .done(done)
    );

    tiled_matrix_multiplier #(.N(3), .P(1), .DATA_W(32)) dut_n3 (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_i(a_i), .a_j(a_j), .a_we(a_we),
        .b_in(b_in), .b_i(b_i), .b_j(b_j), .b_we(b_we),
        .start(start), .acc_mode(acc_mode), .z_i(z_i), .z_j(z_j),
        .z_out(z_out_n3), .busy(busy_n3), .done(done_n3)
    );

    tiled_matrix_multiplier #(.N(4), .P(4), .DATA_W(32)) dut_p4 (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_i(a_i), .a_j(a_j), .a_we(a_we),
        .b_in(b_in), .b_i(b_i), .b_j(b_j), .b_we(b_we),
        .start(start), .acc_mode(acc_mode), .z_i(z_i), .z_j(z_j),
        .z_out(z_out_p4), .busy(busy_p4), .done(done_p4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ab(input int r, input int c, input logic [31:0] av, input logic [31:0] bv);
        a_i = r[1:0]; a_j = c[1:0]; b_i = r[1:0]; b_j = c[1:0];
        a_in = av; b_in = bv; a_we = 1'b1; b_we = 1'b1;
        tick();
        a_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic load_identity();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                write_ab(r, c, (r == c) ? 32'd1 : 32'd0, 32'(4*r + c + 1));
    endtask

    task automatic run_mm(input logic mode, output int lat);
        start = 1'b1; acc_mode = mode;
        tick();
        start = 1'b0; acc_mode = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset busy/done: got %b/%b expected 0/0", busy, done);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                vectors++;
                if (z_out !== '0) begin
                    miscompares++;
                    $display("FAIL reset z[%0d][%0d]: got %0d expected 0", r, c, $signed(z_out));
                end
            end
    endtask

    task automatic test_identity();
        int lat;
        logic [AW-1:0] exp;
        load_identity();
        run_mm(1'b0, lat);
        vectors++;
        if (lat !== 40) begin
            miscompares++;
            $display("FAIL identity latency: got %0d expected 40", lat);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                exp = AW'(4*r + c + 1);
                vectors++;
                if (z_out !== exp) begin
                    miscompares++;
                    $display("FAIL identity z[%0d][%0d]: got %0d expected %0d", r, c, $signed(z_out), $signed(exp));
                end
            end
    endtask

    task automatic test_signed();
        int lat;
        logic [AW-1:0] exp;
        exp = -66'sd8;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                write_ab(r, c, 32'hFFFF_FFFF, 32'd2);
        run_mm(1'b0, lat);
        vectors++;
        if (lat !== 40) begin
            miscompares++;
            $display("FAIL signed latency: got %0d expected 40", lat);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                vectors++;
                if (z_out !== exp) begin
                    miscompares++;
                    $display("FAIL signed z[%0d][%0d]: got %h expected %h", r, c, z_out, exp);
                end
            end
    endtask

    task automatic test_accumulate();
        int lat;
        logic [AW-1:0] exp;
        load_identity();
        run_mm(1'b0, lat);
        run_mm(1'b1, lat);
        vectors++;
        if (lat !== 40) begin
            miscompares++;
            $display("FAIL accumulate latency: got %0d expected 40", lat);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                exp = AW'(2 * (4*r + c + 1));
                vectors++;
                if (z_out !== exp) begin
                    miscompares++;
                    $display("FAIL accumulate z[%0d][%0d]: got %0d expected %0d", r, c, $signed(z_out), $signed(exp));
                end
            end
        run_mm(1'b0, lat);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                exp = AW'(4*r + c + 1);
                vectors++;
                if (z_out !== exp) begin
                    miscompares++;
                    $display("FAIL overwrite z[%0d][%0d]: got %0d expected %0d", r, c, $signed(z_out), $signed(exp));
                end
            end
    endtask

    task automatic test_gating();
        int lat;
        logic [AW-1:0] exp;
        start = 1'b1; acc_mode = 1'b0;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            if (lat == 3) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gating busy: got %b expected 1", busy);
                end
                a_i = 2'd0; a_j = 2'd0; a_in = 32'd99; a_we = 1'b1; start = 1'b1;
            end
            tick();
            a_we = 1'b0; start = 1'b0;
            lat++;
        end
        vectors++;
        if (lat !== 40) begin
            miscompares++;
            $display("FAIL gating latency: got %0d expected 40", lat);
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) run_mm(1'b0, lat);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    z_i = r[1:0]; z_j = c[1:0]; #1;
                    exp = AW'(4*r + c + 1);
                    vectors++;
                    if (z_out !== exp) begin
                        miscompares++;
                        $display("FAIL gating pass%0d z[%0d][%0d]: got %0d expected %0d", pass, r, c, $signed(z_out), $signed(exp));
                    end
                end
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        logic [AW-1:0] exp;
        start = 1'b1; acc_mode = 1'b0;
        tick();
        start = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midop reset busy/done: got %b/%b expected 0/0", busy, done);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                vectors++;
                if (z_out !== '0) begin
                    miscompares++;
                    $display("FAIL midop reset z[%0d][%0d]: got %0d expected 0", r, c, $signed(z_out));
                end
            end
        run_mm(1'b0, lat);
        vectors++;
        if (lat !== 40) begin
            miscompares++;
            $display("FAIL midop rerun latency: got %0d expected 40", lat);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                exp = AW'(4*r + c + 1);
                vectors++;
                if (z_out !== exp) begin
                    miscompares++;
                    $display("FAIL midop rerun z[%0d][%0d]: got %0d expected %0d", r, c, $signed(z_out), $signed(exp));
                end
            end
    endtask

    task automatic test_extremes();
        int lm, ln, lp;
        logic [AW-1:0] exp4, exp3;
        exp4 = AW'(1) << 64;
        exp3 = AW'(3) << 62;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                write_ab(r, c, 32'h8000_0000, 32'h8000_0000);
        start = 1'b1; acc_mode = 1'b0;
        tick();
        start = 1'b0;
        lm = -1; ln = -1; lp = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (done && lm < 0) lm = cyc;
            if (done_n3 && ln < 0) ln = cyc;
            if (done_p4 && lp < 0) lp = cyc;
            if (lm >= 0 && ln >= 0 && lp >= 0) break;
        end
        vectors += 3;
        if (lm !== 40) begin
            miscompares++;
            $display("FAIL extremes latency P=2: got %0d expected 40", lm);
        end
        if (ln !== 36) begin
            miscompares++;
            $display("FAIL extremes latency N=3: got %0d expected 36", ln);
        end
        if (lp !== 20) begin
            miscompares++;
            $display("FAIL extremes latency P=4: got %0d expected 20", lp);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                z_i = r[1:0]; z_j = c[1:0]; #1;
                vectors++;
                if (z_out !== exp4) begin
                    miscompares++;
                    $display("FAIL extremes P=2 z[%0d][%0d]: got %h expected %h", r, c, z_out, exp4);
                end
                vectors++;
                if (z_out_p4 !== exp4) begin
                    miscompares++;
                    $display("FAIL extremes P=4 z[%0d][%0d]: got %h expected %h", r, c, z_out_p4, exp4);
                end
                if (r < 3 && c < 3) begin
                    vectors++;
                    if (z_out_n3 !== exp3) begin
                        miscompares++;
                        $display("FAIL extremes N=3 z[%0d][%0d]: got %h expected %h", r, c, z_out_n3, exp3);
                    end
                end
            end
        z_i = 2'd3; z_j = 2'd0; #1;
        vectors++;
        if (z_out_n3 !== '0) begin
            miscompares++;
            $display("FAIL N=3 out-of-range read: got %h expected 0", z_out_n3);
        end
    endtask

    initial begin
        rst = 1'b1; a_in = '0; b_in = '0; a_i = '0; a_j = '0; b_i = '0; b_j = '0;
        a_we = 1'b0; b_we = 1'b0; start = 1'b0; acc_mode = 1'b0; z_i = '0; z_j = '0;
        test_reset();
        test_identity();
        test_signed();
        test_accumulate();
        test_gating();
        test_reset_midop();
        test_extremes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
